// File: rtl/pipelined_rca_adder.sv
// rtl/pipelined_rca_adder.sv - pipelined ripple-carry adder with valid/ready handshake
//
// Purpose: WIDTH-bit adder split into STAGES equal slices of full_adder cells.
//          Each slice ripples in one cycle. It hands its carry, the sum bits
//          finished so far and the operand bits still pending to the next stage
//          through registers.
// Optional feature: define ADDSUB_EN to add the 'sub' input. With sub=1 the
//          block computes a - b: stage 0 inverts b and forces the carry-in to 1.
// Ports:
//   clk, rst_n          clock, asynchronous active-low reset
//   in_valid/in_ready   input handshake for a, b, cin (and sub)
//   a, b, cin           operands and carry into bit 0
//   sub                 (ADDSUB_EN only) subtract instead of add
//   out_valid/out_ready output handshake for sum, cout, ovf
//   sum, cout, ovf      result, unsigned carry out, signed overflow

module full_adder (
    input  logic a,
    input  logic b,
    input  logic cin,
    output logic sum,
    output logic cout
);
    assign sum  = a ^ b ^ cin;
    assign cout = (a & b) | (cin & (a ^ b));
endmodule

module pipelined_rca_adder #(
    parameter int WIDTH  = 16,
    parameter int STAGES = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
`ifdef ADDSUB_EN
    input  logic             sub,
`endif
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf
);

    localparam int SLICE = WIDTH / STAGES;

    logic [STAGES-1:0] valid_q;
    logic [STAGES:0]   ready;
    // chain[k] is the valid bit offered to stage k; chain[STAGES] is the output.
    logic [STAGES:0]   chain;
    logic [WIDTH-1:0]  b_in;
    logic              cin_in;
    logic              ovf_q;

`ifdef ADDSUB_EN
    assign b_in   = sub ? ~b : b;
    assign cin_in = sub ? 1'b1 : cin;
`else
    assign b_in   = b;
    assign cin_in = cin;
`endif

    assign chain     = {valid_q, in_valid};
    assign out_valid = chain[STAGES];
    assign in_ready  = ready[0];

    // A stage may load when it is empty or when its occupant moves on this edge.
    always_comb begin
        logic r;
        ready         = '0;
        r             = out_ready;
        ready[STAGES] = r;
        for (int k = STAGES - 1; k >= 0; k--) begin
            r        = ~valid_q[k] | r;
            ready[k] = r;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q <= '0;
        end else begin
            for (int k = 0; k < STAGES; k++) begin
                if (ready[k]) begin
                    valid_q[k] <= chain[k];
                end
            end
        end
    end

    for (genvar k = 0; k < STAGES; k++) begin : g_stage
        // Operand bits still to be added when entering stage k.
        localparam int IN_W   = WIDTH - k * SLICE;
        // Sum bits finished after stage k.
        localparam int DONE_W = (k + 1) * SLICE;

        logic [IN_W-1:0]   op_a;
        logic [IN_W-1:0]   op_b;
        logic              c_in;
        logic [SLICE:0]    rc;
        logic [SLICE-1:0]  s_slice;
        logic [DONE_W-1:0] sum_next;
        logic [DONE_W-1:0] sum_q;
        logic              carry_q;
        logic              load;

        assign load = ready[k] & chain[k];

        if (k == 0) begin : g_head
            assign op_a     = a;
            assign op_b     = b_in;
            assign c_in     = cin_in;
            assign sum_next = s_slice;
        end else begin : g_body
            assign op_a     = g_stage[k-1].g_pend.pend_a_q;
            assign op_b     = g_stage[k-1].g_pend.pend_b_q;
            assign c_in     = g_stage[k-1].carry_q;
            assign sum_next = {s_slice, g_stage[k-1].sum_q};
        end

        assign rc[0] = c_in;
        for (genvar i = 0; i < SLICE; i++) begin : g_bit
            full_adder u_fa (
                .a    (op_a[i]),
                .b    (op_b[i]),
                .cin  (rc[i]),
                .sum  (s_slice[i]),
                .cout (rc[i+1])
            );
        end

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                sum_q   <= '0;
                carry_q <= 1'b0;
            end else if (load) begin
                sum_q   <= sum_next;
                carry_q <= rc[SLICE];
            end
        end

        // Upper operand slices travel with the partial sum; the last stage has none.
        if (k < STAGES - 1) begin : g_pend
            logic [IN_W-SLICE-1:0] pend_a_q;
            logic [IN_W-SLICE-1:0] pend_b_q;

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    pend_a_q <= '0;
                    pend_b_q <= '0;
                end else if (load) begin
                    pend_a_q <= op_a[IN_W-1:SLICE];
                    pend_b_q <= op_b[IN_W-1:SLICE];
                end
            end
        end

        // Signed overflow: carry into the MSB differs from carry out of it.
        if (k == STAGES - 1) begin : g_tail
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    ovf_q <= 1'b0;
                end else if (load) begin
                    ovf_q <= rc[SLICE] ^ rc[SLICE-1];
                end
            end
        end
    end

    assign sum  = g_stage[STAGES-1].sum_q;
    assign cout = g_stage[STAGES-1].carry_q;
    assign ovf  = ovf_q;

endmodule

// File: tb/tb_pipelined_rca_adder.sv
// tb/tb_pipelined_rca_adder.sv - directed self-checking bench for pipelined_rca_adder
module tb_pipelined_rca_adder;

    localparam int WIDTH  = 16;
    localparam int STAGES = 4;

    logic             clk       = 1'b0;
    logic             rst_n     = 1'b0;
    logic             in_valid  = 1'b0;
    logic             in_ready;
    logic [WIDTH-1:0] a         = '0;
    logic [WIDTH-1:0] b         = '0;
    logic             cin       = 1'b0;
`ifdef ADDSUB_EN
    logic             sub       = 1'b0;
`endif
    logic             out_valid;
    logic             out_ready = 1'b0;
    logic [WIDTH-1:0] sum;
    logic             cout;
    logic             ovf;

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    pipelined_rca_adder #(.WIDTH(WIDTH), .STAGES(STAGES)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .cin       (cin),
`ifdef ADDSUB_EN
        .sub       (sub),
`endif
        .out_valid (out_valid),
        .out_ready (out_ready),
        .sum       (sum),
        .cout      (cout),
        .ovf       (ovf)
    );

    // Reference result packed as {ovf, cout, sum}.
    function automatic logic [WIDTH+1:0] model(input logic [WIDTH-1:0] x,
                                               input logic [WIDTH-1:0] y,
                                               input logic c);
        logic [WIDTH:0] r;
        logic           v;
        r = {1'b0, x} + {1'b0, y} + {{WIDTH{1'b0}}, c};
        v = (x[WIDTH-1] == y[WIDTH-1]) && (r[WIDTH-1] != x[WIDTH-1]);
        return {v, r[WIDTH], r[WIDTH-1:0]};
    endfunction

    // Sends one operation into an empty pipe and waits for its result.
    task automatic run_single(input logic [WIDTH-1:0] x, input logic [WIDTH-1:0] y,
                              input logic c, output logic [WIDTH+1:0] res, output int lat);
        @(posedge clk); #1;
        a = x; b = y; cin = c; in_valid = 1'b1; out_ready = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        lat = 1;
        while (!out_valid && lat < 20) begin
            @(posedge clk); #1;
            lat++;
        end
        res = {ovf, cout, sum};
    endtask

    task automatic test_reset;
        repeat (2) @(posedge clk);
        #1;
        n_vec++;
        if ({out_valid, in_ready, ovf, cout, sum} !== {1'b0, 1'b1, 1'b0, 1'b0, 16'h0000}) begin
            n_err++;
            $display("FAIL reset_state: got %h expected %h", {out_valid, in_ready, ovf, cout, sum},
                     {1'b0, 1'b1, 1'b0, 1'b0, 16'h0000});
        end
        @(negedge clk); rst_n = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b1; a = 16'h0011; b = 16'h0022; cin = 1'b0; out_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        in_valid = 1'b0;
        #2;
        rst_n = 1'b0;
        #1;
        n_vec++;
        if ({out_valid, in_ready, ovf, cout, sum} !== {1'b0, 1'b1, 1'b0, 1'b0, 16'h0000}) begin
            n_err++;
            $display("FAIL reset_midstream: got %h expected %h", {out_valid, in_ready, ovf, cout, sum},
                     {1'b0, 1'b1, 1'b0, 1'b0, 16'h0000});
        end
        @(negedge clk); rst_n = 1'b1;
        out_ready = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(posedge clk); #1;
            n_vec++;
            if (out_valid !== 1'b0) begin
                n_err++;
                $display("FAIL reset_no_stale: cycle %0d out_valid got %b expected 0", i, out_valid);
            end
        end
    endtask

    task automatic test_carry_ripple;
        logic [WIDTH+1:0] res;
        int               lat;
        run_single(16'hFFFF, 16'h0001, 1'b0, res, lat);
        n_vec++;
        if (lat !== STAGES) begin
            n_err++;
            $display("FAIL ripple_latency: got %0d expected %0d", lat, STAGES);
        end
        n_vec++;
        if (res !== 18'h10000) begin
            n_err++;
            $display("FAIL ripple_result: got %h expected %h", res, 18'h10000);
        end
    endtask

    task automatic test_overflow;
        logic [WIDTH+1:0] res;
        int               lat;
        run_single(16'h7FFF, 16'h0001, 1'b0, res, lat);
        n_vec++;
        if (res !== 18'h28000) begin
            n_err++;
            $display("FAIL ovf_pos: got %h expected %h", res, 18'h28000);
        end
        run_single(16'h8000, 16'h8000, 1'b0, res, lat);
        n_vec++;
        if (res !== 18'h30000) begin
            n_err++;
            $display("FAIL ovf_neg: got %h expected %h", res, 18'h30000);
        end
        run_single(16'hFFFF, 16'hFFFF, 1'b1, res, lat);
        n_vec++;
        if (res !== 18'h1FFFF) begin
            n_err++;
            $display("FAIL cin_all_ones: got %h expected %h", res, 18'h1FFFF);
        end
    endtask

    task automatic test_back_to_back;
        logic [WIDTH-1:0] va  [8] = '{16'h0001, 16'h00FF, 16'h0FFF, 16'hFFFF,
                                      16'h1234, 16'h7000, 16'hABCD, 16'h0000};
        logic [WIDTH-1:0] vb  [8] = '{16'h0002, 16'h0001, 16'h0001, 16'hFFFF,
                                      16'h4321, 16'h1000, 16'h5433, 16'h0000};
        logic             vc  [8] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1};
        logic [WIDTH+1:0] exp [8] = '{18'h00003, 18'h00100, 18'h01000, 18'h1FFFF,
                                      18'h05555, 18'h28000, 18'h10000, 18'h00001};
        int   sent = 0;
        int   got  = 0;
        int   occ  = 0;
        logic saw_stall = 1'b0;
        logic acc, del;
        for (int c = 0; c < 40; c++) begin
            @(posedge clk); #1;
            in_valid  = (sent < 8);
            a         = va[sent % 8];
            b         = vb[sent % 8];
            cin       = vc[sent % 8];
            out_ready = !(c >= 5 && c <= 9);
            #1;
            n_vec++;
            if (in_ready !== ((occ < STAGES) || out_ready)) begin
                n_err++;
                $display("FAIL b2b_in_ready: cycle %0d got %b expected %b", c, in_ready,
                         (occ < STAGES) || out_ready);
            end
            if (!in_ready) saw_stall = 1'b1;
            del = out_valid && out_ready;
            acc = in_valid && in_ready;
            if (del) begin
                n_vec++;
                if (got >= 8 || {ovf, cout, sum} !== exp[got % 8]) begin
                    n_err++;
                    $display("FAIL b2b_result[%0d]: got %h expected %h", got, {ovf, cout, sum},
                             exp[got % 8]);
                end
                got++;
            end
            if (acc) sent++;
            occ = occ + int'(acc) - int'(del);
        end
        in_valid = 1'b0;
        n_vec++;
        if (got !== 8) begin
            n_err++;
            $display("FAIL b2b_count: got %0d expected 8", got);
        end
        n_vec++;
        if (saw_stall !== 1'b1) begin
            n_err++;
            $display("FAIL b2b_stall: in_ready low seen %b expected 1", saw_stall);
        end
    endtask

    task automatic test_random;
        logic [WIDTH+1:0] q[$];
        int   occ = 0;
        logic acc, del;
        for (int c = 0; c < 420; c++) begin
            @(posedge clk); #1;
            if (c < 400) begin
                in_valid  = ($urandom_range(0, 3) != 0);
                out_ready = ($urandom_range(0, 2) != 0);
            end else begin
                in_valid  = 1'b0;
                out_ready = 1'b1;
            end
            a   = WIDTH'($urandom);
            b   = WIDTH'($urandom);
            cin = 1'($urandom);
            #1;
            n_vec++;
            if (in_ready !== ((occ < STAGES) || out_ready)) begin
                n_err++;
                $display("FAIL rand_in_ready: cycle %0d got %b expected %b", c, in_ready,
                         (occ < STAGES) || out_ready);
            end
            del = out_valid && out_ready;
            acc = in_valid && in_ready;
            if (del) begin
                n_vec++;
                if (q.size() == 0) begin
                    n_err++;
                    $display("FAIL rand_extra: cycle %0d got %h expected none", c, {ovf, cout, sum});
                end else begin
                    if ({ovf, cout, sum} !== q[0]) begin
                        n_err++;
                        $display("FAIL rand_result: cycle %0d got %h expected %h", c,
                                 {ovf, cout, sum}, q[0]);
                    end
                    void'(q.pop_front());
                end
            end
            if (acc) q.push_back(model(a, b, cin));
            occ = occ + int'(acc) - int'(del);
        end
        n_vec++;
        if (q.size() != 0) begin
            n_err++;
            $display("FAIL rand_drain: got %0d pending expected 0", q.size());
        end
    endtask

`ifdef ADDSUB_EN
    task automatic test_addsub;
        logic [WIDTH+1:0] res;
        int               lat;
        sub = 1'b1;
        run_single(16'h0005, 16'h0007, 1'b0, res, lat);
        n_vec++;
        if (res !== 18'h0FFFE) begin
            n_err++;
            $display("FAIL sub_small: got %h expected %h", res, 18'h0FFFE);
        end
        run_single(16'h8000, 16'h0001, 1'b0, res, lat);
        n_vec++;
        if (res !== 18'h37FFF) begin
            n_err++;
            $display("FAIL sub_ovf: got %h expected %h", res, 18'h37FFF);
        end
        sub = 1'b0;
    endtask
`endif

    initial begin
        test_reset();
        test_carry_ripple();
        test_overflow();
        test_back_to_back();
        test_random();
`ifdef ADDSUB_EN
        test_addsub();
`endif
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
